mem_read_seq: RTL and testbench

- Multi-cycle SRAM access sequencer that sits directly upstream of the 16-bit data registers (MDR/IR path).
- It accepts a single-cycle read or write request and drives the active-low SRAM strobes for a fixed, parameterised number of wait cycles.
- On reads it captures the returned word and presents it with a one-cycle load strobe that feeds the downstream register's Load/Data_In.
- It reports Busy/Done to the control FSM.

---
 rtl/mem_read_seq.sv | 156 +++++++++++++++
 tb/tb_mem_read_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_seq.sv
`default_nettype none
// ============================================================================
// Module      : mem_read_seq
// Description : Multi-cycle SRAM access sequencer. Accepts a one-cycle read or
//               write request, drives the active-low SRAM strobes for a fixed
//               number of wait cycles, captures read data and hands it to the
//               downstream MDR/IR register with a one-cycle load pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_read_seq #(
  parameter int WAIT_CYCLES = 2,   // strobe-active cycles, legal 1..15
  parameter int ADDR_W      = 20
) (
  input  logic              Clk,
  input  logic              Reset,        // synchronous, active-low
  input  logic              Start,
  input  logic              RW,           // 0 = read, 1 = write
  input  logic [ADDR_W-1:0] Addr,
  input  logic [15:0]       Wr_Data,
  input  logic [15:0]       Mem_Data_In,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [15:0]       Mem_Data_Out,
  output logic              Mem_Data_OE,
  output logic              Mem_CE_N,
  output logic              Mem_OE_N,
  output logic              Mem_WE_N,
  output logic [15:0]       Data_Out,
  output logic              Ld_Out,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  // Counter reload: ACCESS lasts WAIT_CYCLES cycles, exiting when it hits 0.
  localparam logic [3:0] C_LOAD = 4'(WAIT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [15:0]         dout_q, dout_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                doe_q, doe_d;
  logic                ld_q, ld_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                w_strobe;

  // Next-state, datapath and output decode; outputs are derived from the
  // next state so every port comes straight from a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_SETUP;
          rw_d    = RW;
          addr_d  = Addr;
          wdata_d = Wr_Data;
        end
      end
      S_SETUP: begin
        cnt_d   = C_LOAD;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = S_FINISH;
          if (!rw_q) begin
            dout_d = Mem_Data_In;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Chip is selected through SETUP and ACCESS; FINISH releases all strobes
    // while a write keeps driving the bus one extra cycle for data hold.
    w_strobe = (state_d == S_SETUP) || (state_d == S_ACCESS);
    ce_n_d   = !w_strobe;
    oe_n_d   = !(w_strobe && !rw_d);
    we_n_d   = !((state_d == S_ACCESS) && rw_d);
    doe_d    = rw_d && (w_strobe || (state_d == S_FINISH));
    ld_d     = (state_d == S_FINISH) && !rw_d;
    done_d   = (state_d == S_FINISH);
    busy_d   = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 16'd0;
      dout_q  <= 16'd0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      doe_q   <= 1'b0;
      ld_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      doe_q   <= doe_d;
      ld_q    <= ld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Mem_Addr     = addr_q;
  assign Mem_Data_Out = wdata_q;
  assign Mem_Data_OE  = doe_q;
  assign Mem_CE_N     = ce_n_q;
  assign Mem_OE_N     = oe_n_q;
  assign Mem_WE_N     = we_n_q;
  assign Data_Out     = dout_q;
  assign Ld_Out       = ld_q;
  assign Busy         = busy_q;
  assign Done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_read_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_read_seq
// Description : Self-checking bench for mem_read_seq. Two instances (wait of 2
//               and wait of 1) share stimulus; a select picks which one is
//               checked. Per-cycle strobe timeline checks plus a Done-driven
//               scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_read_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Start = 1'b0;
  logic        RW = 1'b0;
  logic [19:0] Addr = '0;
  logic [15:0] Wr_Data = '0;
  logic [15:0] Mem_Data_In = '0;

  logic [19:0] o2_addr, o1_addr, m_addr;
  logic [15:0] o2_mdo, o1_mdo, m_mdo;
  logic [15:0] o2_dout, o1_dout, m_dout;
  logic        o2_doe, o2_ce, o2_oe, o2_we, o2_ld, o2_busy, o2_done;
  logic        o1_doe, o1_ce, o1_oe, o1_we, o1_ld, o1_busy, o1_done;
  logic        m_doe, m_ce, m_oe, m_we, m_ld, m_busy, m_done;
  logic [6:0]  m_vec;
  logic        sel = 1'b0;   // 0: WAIT_CYCLES=2 instance, 1: WAIT_CYCLES=1

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dones = 0;
  logic mon_en = 1'b0;
  logic [15:0] exp_last = 16'd0;

  typedef struct {
    logic        rw;
    logic [19:0] addr;
    logic [15:0] wd;
    logic [15:0] dout;
    int          cyc;
  } sb_t;
  sb_t sb[$];
  sb_t mon_e;

  typedef struct {
    logic        rw;
    logic [19:0] addr;
    logic [15:0] wd;
    logic [15:0] rd;
    logic [15:0] exp_dout;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_read_seq #(.WAIT_CYCLES(2), .ADDR_W(20)) u_dut2 (
    .Clk(clk), .Reset(rst_n), .Start(Start), .RW(RW), .Addr(Addr),
    .Wr_Data(Wr_Data), .Mem_Data_In(Mem_Data_In), .Mem_Addr(o2_addr),
    .Mem_Data_Out(o2_mdo), .Mem_Data_OE(o2_doe), .Mem_CE_N(o2_ce),
    .Mem_OE_N(o2_oe), .Mem_WE_N(o2_we), .Data_Out(o2_dout), .Ld_Out(o2_ld),
    .Busy(o2_busy), .Done(o2_done)
  );

  mem_read_seq #(.WAIT_CYCLES(1), .ADDR_W(20)) u_dut1 (
    .Clk(clk), .Reset(rst_n), .Start(Start), .RW(RW), .Addr(Addr),
    .Wr_Data(Wr_Data), .Mem_Data_In(Mem_Data_In), .Mem_Addr(o1_addr),
    .Mem_Data_Out(o1_mdo), .Mem_Data_OE(o1_doe), .Mem_CE_N(o1_ce),
    .Mem_OE_N(o1_oe), .Mem_WE_N(o1_we), .Data_Out(o1_dout), .Ld_Out(o1_ld),
    .Busy(o1_busy), .Done(o1_done)
  );

  always_comb begin
    m_addr = sel ? o1_addr : o2_addr;
    m_mdo  = sel ? o1_mdo  : o2_mdo;
    m_dout = sel ? o1_dout : o2_dout;
    m_doe  = sel ? o1_doe  : o2_doe;
    m_ce   = sel ? o1_ce   : o2_ce;
    m_oe   = sel ? o1_oe   : o2_oe;
    m_we   = sel ? o1_we   : o2_we;
    m_ld   = sel ? o1_ld   : o2_ld;
    m_busy = sel ? o1_busy : o2_busy;
    m_done = sel ? o1_done : o2_done;
    m_vec  = {m_busy, m_ce, m_oe, m_we, m_doe, m_done, m_ld};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard and strobe invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("oe_we_excl", {31'd0, !(!m_oe && !m_we)}, 32'd1);
      chk("we_needs_ce_doe", {31'd0, m_we || (!m_ce && m_doe)}, 32'd1);
      if (m_done) begin
        dones++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_done actual=1 required=0 at t=%0t", $time);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_done_cyc", cyc, mon_e.cyc);
          chk("sb_ld", {31'd0, m_ld}, {31'd0, !mon_e.rw});
          chk("sb_dout", {16'd0, m_dout}, {16'd0, mon_e.dout});
          chk("sb_addr", {12'd0, m_addr}, {12'd0, mon_e.addr});
          chk("sb_wdata", {16'd0, m_mdo}, {16'd0, mon_e.wd});
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; Start = 1'b1; RW = 1'b0; Addr = 20'hFFFFF; Wr_Data = 16'hFFFF;
    repeat (2) @(negedge clk);
    chk("rst_strobes", {25'd0, m_vec}, 32'h38);
    chk("rst_addr", {12'd0, m_addr}, 32'd0);
    chk("rst_wdata", {16'd0, m_mdo}, 32'd0);
    chk("rst_dout", {16'd0, m_dout}, 32'd0);
    rst_n = 1'b1; Start = 1'b0;
    @(negedge clk);
    chk("rst_idle", {25'd0, m_vec}, 32'h38);
    exp_last = 16'd0;
  endtask

  // One request from IDLE through the following IDLE cycle, checking each
  // cycle's strobe pattern against the documented latency.
  task automatic txn(input logic rw, input logic [19:0] a, input logic [15:0] wd,
                     input logic [15:0] rd, input logic [15:0] exp_d);
    int w;
    sb_t e;
    logic [6:0] ev;
    w = sel ? 1 : 2;
    Start = 1'b1; RW = rw; Addr = a; Wr_Data = wd; Mem_Data_In = rd;
    e.rw = rw; e.addr = a; e.wd = wd; e.dout = exp_d; e.cyc = cyc + 1 + w + 1;
    sb.push_back(e);
    for (int k = 1; k <= w + 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        Start = 1'b0; RW = ~rw; Addr = ~a; Wr_Data = ~wd;
      end else if (k == 2) begin
        Start = 1'b1;          // must be ignored while busy
      end else begin
        Start = 1'b0;
      end
      ev = {k <= w + 2, !(k <= w + 1), !(k <= w + 1 && !rw),
            !(k >= 2 && k <= w + 1 && rw), rw && (k <= w + 2),
            k == w + 2, (k == w + 2) && !rw};
      chk("txn_strobes", {25'd0, m_vec}, {25'd0, ev});
      chk("txn_dout", {16'd0, m_dout}, {16'd0, (k >= w + 2) ? exp_d : exp_last});
      chk("txn_addr", {12'd0, m_addr}, {12'd0, a});
      chk("txn_wdata", {16'd0, m_mdo}, {16'd0, wd});
    end
    exp_last = exp_d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    tbl[0] = '{1'b0, 20'h00123, 16'h0000, 16'hBEEF, 16'hBEEF};
    tbl[1] = '{1'b1, 20'h00040, 16'h1234, 16'h0000, 16'hBEEF};
    tbl[2] = '{1'b0, 20'hFFFFF, 16'h0000, 16'h0000, 16'h0000};
    tbl[3] = '{1'b1, 20'hFFFFF, 16'hFFFF, 16'h1111, 16'h0000};
    tbl[4] = '{1'b0, 20'h00000, 16'h0000, 16'hFFFF, 16'hFFFF};
    tbl[5] = '{1'b1, 20'h0AAAA, 16'h5555, 16'h2222, 16'hFFFF};
    tbl[6] = '{1'b0, 20'h55555, 16'h0000, 16'hA5A5, 16'hA5A5};

    // Reset with Start held high: request must be dropped.
    do_reset();
    mon_en = 1'b1;

    // Table of single requests, issued back to back.
    foreach (tbl[i]) begin
      txn(tbl[i].rw, tbl[i].addr, tbl[i].wd, tbl[i].rd, tbl[i].exp_dout);
      chk("tbl_dout", {16'd0, m_dout}, {16'd0, tbl[i].exp_dout});
    end

    // Start held high continuously with RW toggling every cycle:
    // accepted every 5 cycles, alternating read/write.
    d0 = dones;
    Start = 1'b1;
    for (int jj = 0; jj < 20; jj++) begin
      RW = jj[0];
      Addr = 20'(jj + 256);
      Wr_Data = 16'(jj * 3 + 1);
      Mem_Data_In = 16'(16'hA000 + jj);
      if (jj % 5 == 0) begin
        sb_t e;
        e.rw = jj[0]; e.addr = 20'(jj + 256); e.wd = 16'(jj * 3 + 1);
        e.dout = jj[0] ? exp_last : 16'(16'hA000 + jj + 3);
        e.cyc = cyc + 1 + 3;
        exp_last = e.dout;
        sb.push_back(e);
      end
      @(negedge clk);
      chk("bb_busy", {31'd0, m_busy}, {31'd0, ((jj + 1) % 5) != 0});
    end
    Start = 1'b0;
    repeat (2) @(negedge clk);
    chk("bb_done_count", dones - d0, 32'd4);
    chk("bb_dout", {16'd0, m_dout}, {16'd0, exp_last});

    // Reset in cycle N+2 of a read: no pulses, Data_Out cleared.
    d0 = dones;
    Start = 1'b1; RW = 1'b0; Addr = 20'h00321; Mem_Data_In = 16'h7777;
    @(negedge clk);
    Start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_idle", {25'd0, m_vec}, 32'h38);
    chk("abort_dout", {16'd0, m_dout}, 32'd0);
    chk("abort_addr", {12'd0, m_addr}, 32'd0);
    rst_n = 1'b1;
    exp_last = 16'd0;
    repeat (3) @(negedge clk);
    chk("abort_no_done", dones - d0, 32'd0);
    chk("abort_still_idle", {25'd0, m_vec}, 32'h38);
    txn(1'b0, 20'h00456, 16'h0000, 16'h5A5A, 16'h5A5A);

    // Single wait-cycle instance.
    repeat (3) @(negedge clk);
    sel = 1'b1;
    do_reset();
    txn(1'b0, 20'h00FFF, 16'h0000, 16'h8001, 16'h8001);
    txn(1'b1, 20'h00ABC, 16'hCAFE, 16'h0000, 16'h8001);
    chk("w1_dout", {16'd0, m_dout}, 32'h8001);

    repeat (3) @(negedge clk);
    chk("sb_drain", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
